sysclk_gen: RTL and testbench

Parametrised system-clock generator that replaces the fixed divide-by-100000 counter feeding the core and the seven-segment driver.
- Produces a glitch-free divided clock `sysclk` and a one-cycle `tick` enable.
- Divisor is programmable at run time.
- Supports free-run, halt and single-step modes, so the RISC-V core can be stepped one cycle at a time from board buttons.
- Counts the `sysclk` periods it has emitted.

---
 rtl/sysclk_gen.sv | 129 ++++++++++++
 tb/tb_sysclk_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sysclk_gen.sv
// sysclk_gen - programmable system-clock generator.
//
// Divides the board clock by a run-time programmable divisor to produce
// `sysclk` (high for floor(div/2) cycles, then low) and a one-cycle `tick`
// enable aligned with each sysclk rising edge. The clock can free-run, be
// halted at a period boundary, or be single-stepped one period per step
// edge. Emitted periods are counted in `period_cnt`.
//
// Ports:
//   clk        board clock, all state on its rising edge
//   rst        asynchronous active-high reset
//   div_in     new divisor value (clk cycles per sysclk period)
//   div_load   one-cycle strobe capturing div_in
//   mode       0 = free run, 1 = single-step
//   step       step request, rising edge counts (pre-synchronised)
//   halt       level, stops sysclk at the next period boundary
//   sysclk     divided clock
//   tick       one-clk pulse at each sysclk rising edge
//   running    1 while the clock is producing periods
//   period_cnt number of ticks emitted, wraps at 2^32
module sysclk_gen #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 100000,
  parameter int DIV_MIN     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  input  logic             mode,
  input  logic             step,
  input  logic             halt,
  output logic             sysclk,
  output logic             tick,
  output logic             running,
  output logic [31:0]      period_cnt
);

  localparam logic [CNT_W-1:0] DIV_DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } st_t;

  st_t              st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_cur, div_pend;
  logic             pend_v;
  logic             step_q;

  logic active, bnd, step_rise, apply;
  logic [CNT_W-1:0] div_clamped;

  // Everything visible outside is decoded from registers only.
  assign active    = (st != HALTED);
  assign bnd       = active & (cnt == div_cur - CNT_W'(1));
  assign step_rise = step & ~step_q;
  assign sysclk    = active & (cnt < (div_cur >> 1));
  assign tick      = active & (cnt == '0);
  assign running   = active;

  // A pending divisor only takes effect between periods, so a period is
  // never stretched or shortened by a load.
  assign apply       = pend_v & (bnd | (st == HALTED));
  assign div_clamped = (div_in < DIV_LO) ? DIV_LO : div_in;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      RUN, STEP: begin
        if (bnd) begin
          cnt_nxt = '0;
          // A step period always ends halted; halt/mode only bite here,
          // at the boundary, so the period in flight completes.
          if (st == STEP || halt || mode) st_nxt = HALTED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HALTED: begin
        cnt_nxt = '0;
        if (!halt) begin
          if (!mode)          st_nxt = RUN;
          else if (step_rise) st_nxt = STEP;
        end
      end
      default: begin
        st_nxt  = HALTED;
        cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= RUN;
      cnt     <= '0;
      step_q  <= 1'b0;
    end else begin
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      step_q  <= step;
    end
  end

  // Divisor staging. A load in the same cycle as an apply wins the
  // pending slot, so it lands at the following boundary instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cur  <= DIV_DEF;
      div_pend <= DIV_DEF;
      pend_v   <= 1'b0;
    end else begin
      if (apply)    div_cur  <= div_pend;
      if (div_load) div_pend <= div_clamped;
      pend_v <= div_load | (pend_v & ~apply);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_cnt <= '0;
    else     period_cnt <= period_cnt + 32'(tick);
  end

endmodule

// File: tb/tb_sysclk_gen.sv
module tb_sysclk_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] div_in;
  logic        div_load, mode, step, halt;
  logic        sysclk, tick, running;
  logic [31:0] period_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  sysclk_gen #(.CNT_W(32), .DEFAULT_DIV(4), .DIV_MIN(2)) dut (
    .clk(clk), .rst(rst), .div_in(div_in), .div_load(div_load),
    .mode(mode), .step(step), .halt(halt),
    .sysclk(sysclk), .tick(tick), .running(running), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: "producing" flag, position within the period,
  // divisor in use, a one-deep queue of pending divisors, a one-shot flag
  // for a stepped period, and the emitted-period count.
  bit          m_act, m_one, m_sq;
  int unsigned m_pos, m_div;
  int unsigned m_pend[$];
  logic [31:0] m_pc;

  task automatic model_reset();
    m_act = 1; m_one = 0; m_sq = 0; m_pos = 0; m_div = 4; m_pc = 0;
    m_pend.delete();
  endtask

  // Advance the model by one clk edge with the inputs currently driven.
  task automatic model_step();
    bit at_end;
    at_end = m_act && (m_pos == m_div - 1);
    if (m_act && m_pos == 0) m_pc = m_pc + 1;
    if (m_pend.size() > 0 && (at_end || !m_act)) m_div = m_pend.pop_front();
    if (div_load) begin
      m_pend.delete();
      m_pend.push_back((div_in < 2) ? 2 : div_in);
    end
    if (m_act) begin
      if (at_end) begin
        m_pos = 0;
        if (m_one || halt || mode) begin m_act = 0; m_one = 0; end
      end else m_pos++;
    end else if (!halt) begin
      if (!mode) m_act = 1;
      else if (step && !m_sq) begin m_act = 1; m_one = 1; end
    end
    m_sq = step;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    check("model_sysclk",  32'(sysclk),  32'(m_act && (m_pos < m_div / 2)));
    check("model_tick",    32'(tick),    32'(m_act && m_pos == 0));
    check("model_running", 32'(running), 32'(m_act));
    check("model_pcnt",    period_cnt,   m_pc);
  endtask

  // One clk edge with current inputs, then compare at the falling edge.
  task automatic cyc();
    model_step();
    @(negedge clk);
    chk_model();
  endtask

  task automatic do_reset();
    rst = 1; div_load = 0; div_in = 0; mode = 0; step = 0; halt = 0;
    model_reset();
    #1;
    check("rst_sysclk",  32'(sysclk),  32'd1);
    check("rst_tick",    32'(tick),    32'd1);
    check("rst_running", 32'(running), 32'd1);
    check("rst_pcnt",    period_cnt,   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    bit h, md, ld;
    int unsigned din;
    bit sc, tk, rn;
    int unsigned pc;
  } vec_t;
  vec_t tbl[40];

  initial begin
    // Inputs applied during row k; outputs expected while in row k.
    tbl[0]  = '{0,0,0,0, 1,1,1,0};  tbl[1]  = '{0,0,0,0, 1,0,1,1};
    tbl[2]  = '{0,0,0,0, 0,0,1,1};  tbl[3]  = '{0,0,0,0, 0,0,1,1};
    tbl[4]  = '{0,0,0,0, 1,1,1,1};  tbl[5]  = '{0,0,0,0, 1,0,1,2};
    tbl[6]  = '{0,0,0,0, 0,0,1,2};  tbl[7]  = '{0,0,0,0, 0,0,1,2};
    tbl[8]  = '{0,0,0,0, 1,1,1,2};  tbl[9]  = '{0,0,0,0, 1,0,1,3};
    tbl[10] = '{0,0,0,0, 0,0,1,3};  tbl[11] = '{0,0,0,0, 0,0,1,3};
    tbl[12] = '{0,0,0,0, 1,1,1,3};  tbl[13] = '{1,0,0,0, 1,0,1,4};
    tbl[14] = '{1,0,0,0, 0,0,1,4};  tbl[15] = '{1,0,0,0, 0,0,1,4};
    tbl[16] = '{1,0,0,0, 0,0,0,4};  tbl[17] = '{0,0,0,0, 0,0,0,4};
    tbl[18] = '{0,0,0,0, 1,1,1,4};  tbl[19] = '{0,0,0,0, 1,0,1,5};
    tbl[20] = '{1,0,0,0, 0,0,1,5};  tbl[21] = '{0,0,0,0, 0,0,1,5};
    tbl[22] = '{0,0,0,0, 1,1,1,5};  tbl[23] = '{0,0,1,10,1,0,1,6};
    tbl[24] = '{0,0,0,0, 0,0,1,6};  tbl[25] = '{0,0,0,0, 0,0,1,6};
    tbl[26] = '{0,0,0,0, 1,1,1,6};  tbl[27] = '{0,0,1,1, 1,0,1,7};
    tbl[28] = '{0,0,0,0, 1,0,1,7};  tbl[29] = '{0,0,0,0, 1,0,1,7};
    tbl[30] = '{0,0,0,0, 1,0,1,7};  tbl[31] = '{0,0,0,0, 0,0,1,7};
    tbl[32] = '{0,0,0,0, 0,0,1,7};  tbl[33] = '{0,0,0,0, 0,0,1,7};
    tbl[34] = '{0,0,0,0, 0,0,1,7};  tbl[35] = '{0,0,0,0, 0,0,1,7};
    tbl[36] = '{0,0,0,0, 1,1,1,7};  tbl[37] = '{0,0,0,0, 0,0,1,8};
    tbl[38] = '{0,0,0,0, 1,1,1,8};  tbl[39] = '{0,0,0,0, 0,0,1,9};

    // Reset pattern, halt at boundary, mid-period halt pulse, div change.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      check($sformatf("tbl%0d_sysclk", k),  32'(sysclk),  32'(tbl[k].sc));
      check($sformatf("tbl%0d_tick", k),    32'(tick),    32'(tbl[k].tk));
      check($sformatf("tbl%0d_running", k), 32'(running), 32'(tbl[k].rn));
      check($sformatf("tbl%0d_pcnt", k),    period_cnt,   tbl[k].pc);
      halt = tbl[k].h; mode = tbl[k].md; div_load = tbl[k].ld; div_in = tbl[k].din;
      cyc();
    end
    div_load = 0; halt = 0;

    // Single-step with div=6; a second edge inside the step is ignored.
    do_reset();
    div_load = 1; div_in = 6; mode = 1;
    cyc();
    div_load = 0;
    repeat (5) cyc();
    check("ss_halted", 32'(running), 32'd0);
    check("ss_pcnt0",  period_cnt,   32'd1);
    step = 1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ss_sysclk%0d", i), 32'(sysclk),  32'(i < 3));
      check($sformatf("ss_run%0d", i),    32'(running), 32'd1);
      if (i == 1) step = 0;
      if (i == 2) step = 1;
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ss_after_run%0d", i), 32'(running), 32'd0);
      check($sformatf("ss_after_sc%0d", i),  32'(sysclk),  32'd0);
      cyc();
    end
    check("ss_pcnt1", period_cnt, 32'd2);
    step = 0;

    // period_cnt wrap while halted, then resume.
    force dut.period_cnt = 32'hFFFF_FFFF;
    m_pc = 32'hFFFF_FFFF;
    cyc();
    release dut.period_cnt;
    check("wrap_pre", period_cnt, 32'hFFFF_FFFF);
    mode = 0;
    cyc();
    check("wrap_tick", 32'(tick), 32'd1);
    cyc();
    check("wrap_zero", period_cnt, 32'd0);

    // Async reset mid-period with div=8.
    do_reset();
    div_load = 1; div_in = 8;
    cyc();
    div_load = 0;
    repeat (8) cyc();
    check("ar_pre_sysclk", 32'(sysclk), 32'd0);
    #2 rst = 1;
    #1;
    check("ar_sysclk",  32'(sysclk),  32'd1);
    check("ar_tick",    32'(tick),    32'd1);
    check("ar_running", 32'(running), 32'd1);
    check("ar_pcnt",    period_cnt,   32'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ar_div%0d", i), 32'(sysclk), 32'((i % 4) < 2));
      cyc();
    end

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) halt = ~halt;
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      step = ($urandom_range(0, 3) == 0);
      div_load = ($urandom_range(0, 14) == 0);
      div_in = $urandom_range(0, 12);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
